// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: LSB-first frames with optional even/odd parity
// and one or two stop bits, each bit lasting NB_TICKS baud ticks.
module uart_tx_fifo #(
  parameter int NB_DATA  = 8,
  parameter int NB_TICKS = 16,
  parameter int NB_ADDR  = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_wr_en,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_stop2,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_busy,
  output logic               o_txdone,
  output logic               o_data
);

  localparam int DEPTH = 2 ** NB_ADDR;
  localparam int CW    = NB_ADDR + 1;
  localparam int TW    = (NB_TICKS > 1) ? $clog2(NB_TICKS) : 1;
  localparam int BW    = $clog2(NB_DATA + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(NB_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q;
  logic               push, pop;
  logic [NB_DATA-1:0] head;

  // IDLE waits for data, START/DATA/PARITY/STOP each span whole bit periods
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q;
  logic [TW-1:0]      tick_cnt_q;
  logic [BW-1:0]      bit_cnt_q;
  logic [NB_DATA-1:0] shift_q;
  logic [NB_DATA-1:0] frame_q;
  logic [1:0]         par_mode_q;
  logic               stop2_q;
  logic               data_q;
  logic               busy_q;
  logic               txdone_q;
  logic               bit_end;
  logic               par_en;
  logic               par_bit;

  assign o_full     = (count_q == CNT_FULL);
  assign o_empty    = (count_q == '0);
  assign o_overflow = ovf_q;
  assign o_busy     = busy_q;
  assign o_txdone   = txdone_q;
  assign o_data     = data_q;

  // Pop only sees entries already counted, so a push into an empty FIFO waits a cycle.
  assign push = i_wr_en && !o_full;
  assign pop  = (state_q == S_IDLE) && !o_empty;
  assign head = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= i_wr_en && o_full;
    end
  end

  assign bit_end = i_tick && (tick_cnt_q == TICK_LAST);
  assign par_en  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign par_bit = (^frame_q) ^ par_mode_q[1];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      frame_q    <= '0;
      par_mode_q <= 2'b00;
      stop2_q    <= 1'b0;
      data_q     <= 1'b1;
      busy_q     <= 1'b0;
      txdone_q   <= 1'b0;
    end else begin
      txdone_q <= 1'b0;
      if (i_tick && (state_q != S_IDLE)) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q    <= head;
            frame_q    <= head;
            par_mode_q <= i_parity_mode;
            stop2_q    <= i_stop2;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            data_q  <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              if (par_en) begin
                data_q  <= par_bit;
                state_q <= S_PARITY;
              end else begin
                data_q  <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              data_q    <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            data_q  <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop2_q && (bit_cnt_q == '0)) begin
              bit_cnt_q <= BW'(1);
            end else begin
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              txdone_q  <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        default: begin
          data_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model compared every cycle,
// plus directed line captures checked against hand-computed bit patterns.
module tb_uart_tx_fifo;

  localparam int NB_DATA  = 8;
  localparam int NB_TICKS = 16;
  localparam int NB_ADDR  = 4;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_tick;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic [1:0] i_parity_mode;
  logic       i_stop2;
  logic       o_full, o_empty, o_overflow, o_busy, o_txdone, o_data;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  uart_tx_fifo #(.NB_DATA(NB_DATA), .NB_TICKS(NB_TICKS), .NB_ADDR(NB_ADDR)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_tick        (i_tick),
    .i_wr_en       (i_wr_en),
    .i_wr_data     (i_wr_data),
    .i_parity_mode (i_parity_mode),
    .i_stop2       (i_stop2),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy),
    .o_txdone      (o_txdone),
    .o_data        (o_data)
  );

  initial forever #5 clk = ~clk;

  // baud strobe: one clk in every four
  initial begin
    int tph;
    tph = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      tph = (tph + 1) % 4;
      i_tick = (tph == 0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the list of line levels left in the current frame.
  logic [7:0] mq[$];
  logic       mbits[$];
  int         m_ticks;
  bit         m_act;
  bit         m_was_full;
  logic [7:0] m_b;
  logic       e_data, e_busy, e_txdone, e_ovf, e_full, e_empty;

  initial begin
    m_act = 1'b0;
    e_data = 1'b1; e_busy = 1'b0; e_txdone = 1'b0; e_ovf = 1'b0;
    e_full = 1'b0; e_empty = 1'b1;
    forever begin
      @(posedge clk);
      if (i_rst) begin
        mq.delete();
        mbits.delete();
        m_act = 1'b0;
        e_data = 1'b1; e_busy = 1'b0; e_txdone = 1'b0; e_ovf = 1'b0;
      end else begin
        m_was_full = (mq.size() == DEPTH);
        e_txdone = 1'b0;
        e_ovf = i_wr_en && m_was_full;
        if (!m_act) begin
          if (mq.size() != 0) begin
            m_b = mq.pop_front();
            mbits.delete();
            mbits.push_back(1'b0);
            for (int i = 0; i < NB_DATA; i++) mbits.push_back(m_b[i]);
            if (i_parity_mode == 2'b01) mbits.push_back(^m_b);
            if (i_parity_mode == 2'b10) mbits.push_back(~^m_b);
            mbits.push_back(1'b1);
            if (i_stop2) mbits.push_back(1'b1);
            m_act = 1'b1;
            m_ticks = NB_TICKS;
          end
        end else if (i_tick) begin
          m_ticks--;
          if (m_ticks == 0) begin
            void'(mbits.pop_front());
            if (mbits.size() == 0) begin
              m_act = 1'b0;
              e_txdone = 1'b1;
            end else begin
              m_ticks = NB_TICKS;
            end
          end
        end
        if (i_wr_en && !m_was_full) mq.push_back(i_wr_data);
        e_data = m_act ? mbits[0] : 1'b1;
        e_busy = m_act;
      end
      e_empty = (mq.size() == 0);
      e_full  = (mq.size() == DEPTH);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("m_data",     32'(o_data),     32'(e_data));
      check("m_busy",     32'(o_busy),     32'(e_busy));
      check("m_txdone",   32'(o_txdone),   32'(e_txdone));
      check("m_overflow", 32'(o_overflow), 32'(e_ovf));
      check("m_full",     32'(o_full),     32'(e_full));
      check("m_empty",    32'(o_empty),    32'(e_empty));
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_txdone === 1'b1) n_done++;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    i_wr_en = 1'b1;
    i_wr_data = b;
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic wait_level(input string nm, input logic lvl, input int max);
    int n = 0;
    while (o_data !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(o_data), 32'(lvl));
  endtask

  task automatic wait_txdone(input string nm, input int max);
    int n = 0;
    while (o_txdone !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(o_txdone), 1);
  endtask

  // Samples the line at the centre of each bit; s[0] is the start bit.
  task automatic get_frame(input string nm, input int nsamp, output logic [15:0] s);
    s = '0;
    wait_level({nm, "_start"}, 1'b0, 3000);
    repeat (32) @(negedge clk);
    for (int i = 0; i < nsamp; i++) begin
      if (i > 0) repeat (64) @(negedge clk);
      s[i] = o_data;
    end
  endtask

  logic [15:0] s;
  logic [9:0]  exp10;
  logic [7:0]  kb;
  int          d0, n;

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_data = 8'h00;
    i_parity_mode = 2'b00; i_stop2 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;

    // idle after reset
    d0 = n_done;
    repeat (1000) @(negedge clk);
    check("idle_data",   32'(o_data),  1);
    check("idle_empty",  32'(o_empty), 1);
    check("idle_busy",   32'(o_busy),  0);
    check("idle_txdone", 32'(n_done - d0), 0);

    // 0xA5, no parity, one stop
    d0 = n_done;
    push(8'hA5);
    get_frame("a5", 10, s);
    check("a5_line", 32'(s[9:0]), 32'(10'b1101001010));
    wait_txdone("a5_done", 200);
    repeat (5) @(negedge clk);
    check("a5_txdone_cnt", 32'(n_done - d0), 1);
    check("a5_empty", 32'(o_empty), 1);

    push(8'hA5);
    wait_level("bl_start", 1'b0, 100);
    wait_level("bl_b0", 1'b1, 200);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_data === 1'b1 && n < 200);
    check("bit_len", 32'(n), 64);
    wait_txdone("bl_done", 1000);
    repeat (3) @(negedge clk);

    // 0x3C even + two stops, then 0x3C odd + one stop; config change mid-frame
    i_parity_mode = 2'b01; i_stop2 = 1'b1;
    push(8'h3C);
    repeat (3) @(negedge clk);
    i_parity_mode = 2'b10; i_stop2 = 1'b0;
    push(8'h3C);
    get_frame("even", 10, s);
    check("even_line", 32'(s[9:0]), 32'(10'b0001111000));
    wait_level("even_stop_rise", 1'b1, 100);
    n = 0;
    while (o_txdone !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("stop2_len", 32'(n), 128);
    @(negedge clk);
    check("par_gap", 32'(o_data), 0);
    get_frame("odd", 10, s);
    check("odd_line", 32'(s[9:0]), 32'(10'b1001111000));
    wait_txdone("odd_done", 200);
    repeat (3) @(negedge clk);

    // fill to full while a frame is in flight; 17th push overflows
    i_parity_mode = 2'b00; i_stop2 = 1'b0;
    d0 = n_done;
    push(8'h5A);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 14) check("full_early", 32'(o_full), 0);
      if (i == 15) check("full_16", 32'(o_full), 1);
      if (i == 16) check("ovf_pulse", 32'(o_overflow), 1);
    end
    @(negedge clk);
    check("ovf_end", 32'(o_overflow), 0);
    check("full_hold", 32'(o_full), 1);
    wait_txdone("inflight_done", 1000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("b2b_gap", 32'(o_data), 0);
      get_frame("burst", 10, s);
      kb = 8'(k);
      exp10 = {1'b1, kb, 1'b0};
      check("burst_frame", 32'(s[9:0]), 32'(exp10));
      wait_txdone("burst_done", 200);
    end
    repeat (5) @(negedge clk);
    check("burst_txdone_cnt", 32'(n_done - d0), 17);
    check("burst_empty", 32'(o_empty), 1);
    repeat (800) @(negedge clk);
    check("no_0x10", 32'(n_done - d0), 17);
    check("no_0x10_line", 32'(o_data), 1);

    // push on the same cycle IDLE pops the single entry
    push(8'hC3);
    push(8'h81);
    check("pp_empty", 32'(o_empty), 0);
    check("pp_full", 32'(o_full), 0);
    check("pp_ovf", 32'(o_overflow), 0);
    get_frame("pp1", 10, s);
    check("pp1_frame", 32'(s[9:0]), 32'({1'b1, 8'hC3, 1'b0}));
    wait_txdone("pp1_done", 200);
    @(negedge clk);
    get_frame("pp2", 10, s);
    check("pp2_frame", 32'(s[9:0]), 32'({1'b1, 8'h81, 1'b0}));
    wait_txdone("pp2_done", 200);
    repeat (3) @(negedge clk);
    check("pp_empty_end", 32'(o_empty), 1);

    // reset during data bit 3 of 0xFF with a second byte queued
    push(8'hFF);
    push(8'h12);
    wait_level("rst_start", 1'b0, 100);
    repeat (32 + 64 * 4) @(negedge clk);
    check("rst_pre_busy", 32'(o_busy), 1);
    check("rst_pre_empty", 32'(o_empty), 0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_data", 32'(o_data), 1);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_busy", 32'(o_busy), 0);
    d0 = n_done;
    repeat (200) @(negedge clk);
    check("rst_discard", 32'(n_done - d0), 0);
    push(8'h55);
    get_frame("post_rst", 10, s);
    check("post_rst_frame", 32'(s[9:0]), 32'({1'b1, 8'h55, 1'b0}));
    wait_txdone("post_rst_done", 200);
    repeat (700) @(negedge clk);
    check("post_rst_cnt", 32'(n_done - d0), 1);
    check("post_rst_idle", 32'(o_data), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
